// File: rtl/arty_dma_axi_pkg.sv
// rtl/arty_dma_axi_pkg.sv - shared state, packet and AXI encodings for the DMA-to-AXI bridge
`define ARTY_DMA_PKT_S(aw) struct packed { logic write_not_read; logic [(aw)-1:0] addr; }

package arty_dma_axi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_ADDR,
      RD_DATA,
      WR_ADDR,
      WR_DATA,
      WR_RESP
   } bridge_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // Index width that stays at least one bit wide for a single channel.
   function automatic int safe_clog2(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arty_rr_arb.sv
// rtl/arty_rr_arb.sv - round-robin arbiter with grant enable and pointer advance on grant
module arty_rr_arb
   import arty_dma_axi_pkg::*;
#(
   parameter int num_p = 2,
   localparam int id_w_lp = safe_clog2(num_p)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic [num_p-1:0]   req_i,
   output logic [num_p-1:0]   grant_o,
   output logic [id_w_lp-1:0] grant_id_o,
   output logic               grant_v_o
);

   logic [id_w_lp-1:0] ptr_r;
   logic [id_w_lp:0]   slot;
   logic [id_w_lp-1:0] idx;
   logic               found;

   // Scan from the pointer upward, wrapping, and take the first requester.
   always_comb begin
      grant_o    = '0;
      grant_id_o = '0;
      found      = 1'b0;
      slot       = '0;
      idx        = '0;
      for (int i = 0; i < num_p; i++) begin
         slot = {1'b0, ptr_r} + (id_w_lp+1)'(i);
         if (slot >= (id_w_lp+1)'(num_p))
            slot = slot - (id_w_lp+1)'(num_p);
         idx = slot[id_w_lp-1:0];
         if (en_i && !found && req_i[idx]) begin
            found       = 1'b1;
            grant_o[idx] = 1'b1;
            grant_id_o  = idx;
         end
      end
   end

   assign grant_v_o = found;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         ptr_r <= '0;
      else if (grant_v_o)
         ptr_r <= (grant_id_o == id_w_lp'(num_p-1)) ? '0 : grant_id_o + 1'b1;
   end

endmodule

// File: rtl/arty_dma_axi_bridge.sv
// rtl/arty_dma_axi_bridge.sv - N-channel bsg_cache DMA to AXI4 burst bridge, one transaction in flight
module arty_dma_axi_bridge
   import arty_dma_axi_pkg::*;
#(
   parameter int addr_width_p          = 28,
   parameter int data_width_p          = 64,
   parameter int block_size_in_words_p = 8,
   parameter int num_cache_p           = 2,
   parameter int axi_id_width_p        = 4
) (
   input  logic                                   clk_i,
   input  logic                                   reset_i,

   input  logic [num_cache_p*(1+addr_width_p)-1:0] dma_pkt_i,
   input  logic [num_cache_p-1:0]                 dma_pkt_v_i,
   output logic [num_cache_p-1:0]                 dma_pkt_yumi_o,

   output logic [data_width_p-1:0]                dma_data_o,
   output logic [num_cache_p-1:0]                 dma_data_v_o,
   input  logic [num_cache_p-1:0]                 dma_data_ready_and_i,

   input  logic [num_cache_p*data_width_p-1:0]    dma_data_i,
   input  logic [num_cache_p-1:0]                 dma_data_v_i,
   output logic [num_cache_p-1:0]                 dma_data_yumi_o,

   output logic [axi_id_width_p-1:0]              axi_awid_o,
   output logic [addr_width_p-1:0]                axi_awaddr_o,
   output logic [7:0]                             axi_awlen_o,
   output logic [2:0]                             axi_awsize_o,
   output logic [1:0]                             axi_awburst_o,
   output logic                                   axi_awvalid_o,
   input  logic                                   axi_awready_i,

   output logic [data_width_p-1:0]                axi_wdata_o,
   output logic [data_width_p/8-1:0]              axi_wstrb_o,
   output logic                                   axi_wlast_o,
   output logic                                   axi_wvalid_o,
   input  logic                                   axi_wready_i,

   input  logic [axi_id_width_p-1:0]              axi_bid_i,
   input  logic [1:0]                             axi_bresp_i,
   input  logic                                   axi_bvalid_i,
   output logic                                   axi_bready_o,

   output logic [axi_id_width_p-1:0]              axi_arid_o,
   output logic [addr_width_p-1:0]                axi_araddr_o,
   output logic [7:0]                             axi_arlen_o,
   output logic [2:0]                             axi_arsize_o,
   output logic [1:0]                             axi_arburst_o,
   output logic                                   axi_arvalid_o,
   input  logic                                   axi_arready_i,

   input  logic [axi_id_width_p-1:0]              axi_rid_i,
   input  logic [data_width_p-1:0]                axi_rdata_i,
   input  logic [1:0]                             axi_rresp_i,
   input  logic                                   axi_rlast_i,
   input  logic                                   axi_rvalid_i,
   output logic                                   axi_rready_o,

   output logic                                   error_o,
   output logic [safe_clog2(num_cache_p)-1:0]     error_cache_id_o
);

   localparam int id_w_lp    = safe_clog2(num_cache_p);
   localparam int pkt_w_lp   = 1 + addr_width_p;
   localparam int blk_off_lp = $clog2(block_size_in_words_p*data_width_p/8);
   localparam logic [7:0] len_lp  = 8'(block_size_in_words_p-1);
   localparam logic [2:0] size_lp = 3'($clog2(data_width_p/8));
   localparam logic [addr_width_p-1:0] blk_mask_lp = {addr_width_p{1'b1}} << blk_off_lp;

   typedef `ARTY_DMA_PKT_S(addr_width_p) dma_pkt_s;

   dma_pkt_s                 pkt_arr   [num_cache_p];
   logic [data_width_p-1:0]  wdata_arr [num_cache_p];

   bridge_state_e            state_q, state_n;
   logic [addr_width_p-1:0]  addr_r;
   logic [id_w_lp-1:0]       id_r;
   logic [7:0]               cnt_r;
   logic                     error_r;
   logic [id_w_lp-1:0]       err_id_r;

   logic [num_cache_p-1:0]   grant;
   logic [id_w_lp-1:0]       grant_id;
   logic                     grant_v;
   logic                     last_beat;
   logic                     ar_hs, aw_hs, r_hs, w_hs, b_hs, err_ev;
   logic                     unused_ids;

   always_comb begin
      for (int c = 0; c < num_cache_p; c++) begin
         pkt_arr[c]   = dma_pkt_i[c*pkt_w_lp +: pkt_w_lp];
         wdata_arr[c] = dma_data_i[c*data_width_p +: data_width_p];
      end
   end

   arty_rr_arb #(.num_p(num_cache_p)) u_arb (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .en_i       (state_q == IDLE),
      .req_i      (dma_pkt_v_i),
      .grant_o    (grant),
      .grant_id_o (grant_id),
      .grant_v_o  (grant_v)
   );

   assign dma_pkt_yumi_o = grant;
   assign last_beat      = (cnt_r == len_lp);

   assign ar_hs  = axi_arvalid_o & axi_arready_i;
   assign aw_hs  = axi_awvalid_o & axi_awready_i;
   assign r_hs   = axi_rvalid_i  & axi_rready_o;
   assign w_hs   = axi_wvalid_o  & axi_wready_i;
   assign b_hs   = axi_bvalid_i  & axi_bready_o;
   assign err_ev = (r_hs && ((axi_rlast_i != last_beat) || (axi_rresp_i != AXI_RESP_OKAY)))
                || (b_hs && (axi_bresp_i != AXI_RESP_OKAY));

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
         state_q <= IDLE;
      else
         state_q <= state_n;
   end

   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:    if (grant_v) state_n = pkt_arr[grant_id].write_not_read ? WR_ADDR : RD_ADDR;
         RD_ADDR: if (ar_hs) state_n = RD_DATA;
         RD_DATA: if (r_hs && last_beat) state_n = IDLE;
         WR_ADDR: if (aw_hs) state_n = WR_DATA;
         WR_DATA: if (w_hs && last_beat) state_n = WR_RESP;
         WR_RESP: if (b_hs) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      axi_arvalid_o   = 1'b0;
      axi_awvalid_o   = 1'b0;
      axi_rready_o    = 1'b0;
      axi_wvalid_o    = 1'b0;
      axi_wlast_o     = 1'b0;
      axi_bready_o    = 1'b0;
      dma_data_v_o    = '0;
      dma_data_yumi_o = '0;
      case (state_q)
         RD_ADDR: axi_arvalid_o = 1'b1;
         RD_DATA: begin
            axi_rready_o       = dma_data_ready_and_i[id_r];
            dma_data_v_o[id_r] = axi_rvalid_i;
         end
         WR_ADDR: axi_awvalid_o = 1'b1;
         WR_DATA: begin
            axi_wvalid_o          = dma_data_v_i[id_r];
            axi_wlast_o           = last_beat;
            dma_data_yumi_o[id_r] = dma_data_v_i[id_r] & axi_wready_i;
         end
         WR_RESP: axi_bready_o = 1'b1;
         default: ;
      endcase
   end

   assign axi_awid_o    = axi_id_width_p'(id_r);
   assign axi_awaddr_o  = addr_r;
   assign axi_awlen_o   = len_lp;
   assign axi_awsize_o  = size_lp;
   assign axi_awburst_o = AXI_BURST_INCR;
   assign axi_arid_o    = axi_id_width_p'(id_r);
   assign axi_araddr_o  = addr_r;
   assign axi_arlen_o   = len_lp;
   assign axi_arsize_o  = size_lp;
   assign axi_arburst_o = AXI_BURST_INCR;
   assign axi_wdata_o   = wdata_arr[id_r];
   assign axi_wstrb_o   = '1;
   assign dma_data_o    = axi_rdata_i;

   assign error_o          = error_r;
   assign error_cache_id_o = err_id_r;

   // Response IDs are implied by the single outstanding transaction.
   assign unused_ids = ^{axi_bid_i, axi_rid_i};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         addr_r   <= '0;
         id_r     <= '0;
         cnt_r    <= '0;
         error_r  <= 1'b0;
         err_id_r <= '0;
      end else begin
         if (grant_v) begin
            addr_r <= pkt_arr[grant_id].addr & blk_mask_lp;
            id_r   <= grant_id;
         end
         if (ar_hs || aw_hs)
            cnt_r <= '0;
         else if (r_hs || w_hs)
            cnt_r <= cnt_r + 8'd1;
         // Only the first offending channel is recorded.
         if (err_ev) begin
            error_r <= 1'b1;
            if (!error_r)
               err_id_r <= id_r;
         end
      end
   end

endmodule

// File: tb/tb_arty_dma_axi_bridge.sv
// tb/tb_arty_dma_axi_bridge.sv - table-driven self-checking bench for arty_dma_axi_bridge
module tb_arty_dma_axi_bridge;

   logic        clk = 1'b0;
   logic        reset_i;
   logic [57:0] dma_pkt_i;
   logic [1:0]  dma_pkt_v_i, dma_pkt_yumi_o;
   logic [63:0] dma_data_o;
   logic [1:0]  dma_data_v_o, dma_data_ready_and_i;
   logic [127:0] dma_data_i;
   logic [1:0]  dma_data_v_i, dma_data_yumi_o;
   logic [3:0]  axi_awid_o, axi_arid_o, axi_bid_i, axi_rid_i;
   logic [27:0] axi_awaddr_o, axi_araddr_o;
   logic [7:0]  axi_awlen_o, axi_arlen_o, axi_wstrb_o;
   logic [2:0]  axi_awsize_o, axi_arsize_o;
   logic [1:0]  axi_awburst_o, axi_arburst_o, axi_bresp_i, axi_rresp_i;
   logic        axi_awvalid_o, axi_awready_i, axi_arvalid_o, axi_arready_i;
   logic [63:0] axi_wdata_o, axi_rdata_i;
   logic        axi_wlast_o, axi_wvalid_o, axi_wready_i;
   logic        axi_bvalid_i, axi_bready_o;
   logic        axi_rlast_i, axi_rvalid_i, axi_rready_o;
   logic        error_o;
   logic [0:0]  error_cache_id_o;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   arty_dma_axi_bridge dut (
      .clk_i(clk), .reset_i(reset_i),
      .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
      .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_and_i(dma_data_ready_and_i),
      .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
      .axi_awid_o(axi_awid_o), .axi_awaddr_o(axi_awaddr_o), .axi_awlen_o(axi_awlen_o),
      .axi_awsize_o(axi_awsize_o), .axi_awburst_o(axi_awburst_o), .axi_awvalid_o(axi_awvalid_o),
      .axi_awready_i(axi_awready_i),
      .axi_wdata_o(axi_wdata_o), .axi_wstrb_o(axi_wstrb_o), .axi_wlast_o(axi_wlast_o),
      .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
      .axi_bid_i(axi_bid_i), .axi_bresp_i(axi_bresp_i), .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
      .axi_arid_o(axi_arid_o), .axi_araddr_o(axi_araddr_o), .axi_arlen_o(axi_arlen_o),
      .axi_arsize_o(axi_arsize_o), .axi_arburst_o(axi_arburst_o), .axi_arvalid_o(axi_arvalid_o),
      .axi_arready_i(axi_arready_i),
      .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i), .axi_rresp_i(axi_rresp_i),
      .axi_rlast_i(axi_rlast_i), .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
      .error_o(error_o), .error_cache_id_o(error_cache_id_o)
   );

   typedef struct {
      logic [1:0]  req;
      logic        wnr;
      logic [27:0] addr;
      logic [1:0]  resp;
      logic        bad_last;
      int          exp_ch;
      logic [27:0] exp_addr;
      logic        err_pre;
      logic        exp_err;
      logic        exp_eid;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] rd_pat(input int k, input int b);
      return 64'hA5A5_0000_0000_0000 | (64'(k) << 8) | 64'(b);
   endfunction

   function automatic logic [63:0] wr_pat(input int k, input int b);
      return (64'(k) << 32) | 64'(b);
   endfunction

   task automatic start_txn(input string tag, input logic [1:0] req, input logic wnr,
                            input logic [27:0] addr, input int ch, input logic [27:0] exp_addr);
      @(negedge clk);
      dma_pkt_i   = {wnr, addr, wnr, addr};
      dma_pkt_v_i = req;
      #1 chk({tag, "_yumi"}, 64'(dma_pkt_yumi_o), 64'(1) << ch);
      @(negedge clk);
      #1 chk({tag, "_yumi_busy"}, 64'(dma_pkt_yumi_o), 64'd0);
      if (wnr) begin
         chk({tag, "_aw"}, {axi_awvalid_o, axi_awid_o, axi_awlen_o, axi_awsize_o, axi_awburst_o, axi_awaddr_o},
             {1'b1, 4'(ch), 8'd7, 3'd3, 2'b01, exp_addr});
         chk({tag, "_arv"}, 64'(axi_arvalid_o), 64'd0);
      end else begin
         chk({tag, "_ar"}, {axi_arvalid_o, axi_arid_o, axi_arlen_o, axi_arsize_o, axi_arburst_o, axi_araddr_o},
             {1'b1, 4'(ch), 8'd7, 3'd3, 2'b01, exp_addr});
         chk({tag, "_awv"}, 64'(axi_awvalid_o), 64'd0);
      end
      dma_pkt_v_i = '0;
      @(negedge clk);
      #1 chk({tag, "_ahold"}, 64'(wnr ? axi_awvalid_o : axi_arvalid_o), 64'd1);
      if (wnr) axi_awready_i = 1'b1;
      else     axi_arready_i = 1'b1;
   endtask

   task automatic rd_beats(input string tag, input int ch, input int k, input logic [1:0] resp,
                           input logic bad_last, input logic exp_err, input logic exp_eid);
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         axi_arready_i        = 1'b0;
         axi_rvalid_i         = 1'b1;
         axi_rdata_i          = rd_pat(k, b);
         axi_rlast_i          = bad_last ? 1'b0 : (b == 7);
         axi_rresp_i          = resp;
         dma_data_ready_and_i = 2'(1 << ch);
         #1 chk({tag, "_r"}, {axi_rready_o, dma_data_v_o}, {1'b1, 2'(1 << ch)});
         chk({tag, "_rdata"}, dma_data_o, rd_pat(k, b));
      end
      @(negedge clk);
      axi_rvalid_i         = 1'b0;
      axi_rlast_i          = 1'b0;
      axi_rresp_i          = 2'b00;
      dma_data_ready_and_i = 2'b11;
      #1 chk({tag, "_ridle"}, {axi_rready_o, dma_data_v_o, axi_arvalid_o}, 64'd0);
      chk({tag, "_err"}, {error_o, error_cache_id_o}, {exp_err, exp_eid});
   endtask

   task automatic wr_beats(input string tag, input int ch, input int k, input logic [1:0] resp,
                           input logic err_pre, input logic exp_err, input logic exp_eid);
      logic [63:0] d;
      for (int b = 0; b < 8; b++) begin
         @(negedge clk);
         d             = wr_pat(k, b);
         axi_awready_i = 1'b0;
         axi_wready_i  = 1'b1;
         dma_data_v_i  = 2'(1 << ch);
         dma_data_i    = (ch == 1) ? {d, ~d} : {~d, d};
         #1 chk({tag, "_w"}, {axi_wvalid_o, axi_wstrb_o, axi_wlast_o, dma_data_yumi_o},
                {1'b1, 8'hFF, (b == 7), 2'(1 << ch)});
         chk({tag, "_wdata"}, axi_wdata_o, d);
      end
      @(negedge clk);
      axi_wready_i = 1'b0;
      dma_data_v_i = 2'b00;
      axi_bvalid_i = 1'b1;
      axi_bresp_i  = resp;
      #1 chk({tag, "_b"}, {axi_bready_o, axi_wvalid_o, error_o}, {1'b1, 1'b0, err_pre});
      @(negedge clk);
      axi_bvalid_i = 1'b0;
      axi_bresp_i  = 2'b00;
      #1 chk({tag, "_end"}, {axi_bready_o, axi_awvalid_o, error_o, error_cache_id_o},
             {1'b0, 1'b0, exp_err, exp_eid});
   endtask

   task automatic run_vec(input vec_t v, input int k);
      string tag;
      tag = $sformatf("v%0d", k);
      start_txn(tag, v.req, v.wnr, v.addr, v.exp_ch, v.exp_addr);
      if (v.wnr) wr_beats(tag, v.exp_ch, k, v.resp, v.err_pre, v.exp_err, v.exp_eid);
      else       rd_beats(tag, v.exp_ch, k, v.resp, v.bad_last, v.exp_err, v.exp_eid);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      int b;
      logic rv, rdy;

      //             req   wnr  addr          resp  badl ch exp_addr      pre  err  eid
      vecs[0] = '{2'b01, 1'b0, 28'h0000047, 2'b00, 1'b0, 0, 28'h0000040, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 1'b1, 28'h0001000, 2'b00, 1'b0, 1, 28'h0001000, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{2'b11, 1'b0, 28'h0012345, 2'b00, 1'b0, 0, 28'h0012340, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{2'b11, 1'b1, 28'h0ABCDEF, 2'b00, 1'b0, 1, 28'h0ABCDC0, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{2'b11, 1'b0, 28'hFFFFFFF, 2'b00, 1'b0, 0, 28'hFFFFFC0, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{2'b11, 1'b1, 28'h0000080, 2'b00, 1'b0, 1, 28'h0000080, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{2'b10, 1'b1, 28'h00002A5, 2'b10, 1'b0, 1, 28'h0000280, 1'b0, 1'b1, 1'b1};
      vecs[7] = '{2'b01, 1'b0, 28'h000003F, 2'b00, 1'b0, 0, 28'h0000000, 1'b1, 1'b1, 1'b1};
      vecs[8] = '{2'b11, 1'b0, 28'h00007C1, 2'b00, 1'b1, 0, 28'h00007C0, 1'b0, 1'b1, 1'b0};

      reset_i = 1'b1;
      dma_pkt_i = '0;  dma_pkt_v_i = '0;
      dma_data_i = '0; dma_data_v_i = 2'b11; dma_data_ready_and_i = 2'b11;
      axi_awready_i = 1'b1; axi_arready_i = 1'b1; axi_wready_i = 1'b1;
      axi_bid_i = '0; axi_bresp_i = 2'b00; axi_bvalid_i = 1'b1;
      axi_rid_i = '0; axi_rdata_i = '0; axi_rresp_i = 2'b00; axi_rlast_i = 1'b0; axi_rvalid_i = 1'b1;
      repeat (3) @(negedge clk);
      reset_i = 1'b0;
      #1 chk("reset_outs", {dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o, axi_awvalid_o, axi_arvalid_o,
                            axi_wvalid_o, axi_bready_o, axi_rready_o, error_o, error_cache_id_o}, 64'd0);
      axi_awready_i = 1'b0; axi_arready_i = 1'b0; axi_wready_i = 1'b0;
      axi_bvalid_i = 1'b0; axi_rvalid_i = 1'b0; dma_data_v_i = 2'b00;

      for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

      // Read with ready toggling and rvalid gapped.
      start_txn("t4", 2'b01, 1'b0, 28'h0000200, 0, 28'h0000200);
      b = 0;
      for (int c = 0; c < 60 && b < 8; c++) begin
         @(negedge clk);
         axi_arready_i        = 1'b0;
         rv                   = (c % 3) != 2;
         rdy                  = (c % 2) == 1;
         axi_rvalid_i         = rv;
         axi_rdata_i          = rd_pat(20, b);
         axi_rlast_i          = (b == 7);
         axi_rresp_i          = 2'b00;
         dma_data_ready_and_i = {~rdy, rdy};
         #1 chk("t4_rready", 64'(axi_rready_o), 64'(rdy));
         chk("t4_v", 64'(dma_data_v_o), {62'd0, 1'b0, rv});
         if (rv && rdy) begin
            chk("t4_data", dma_data_o, rd_pat(20, b));
            b++;
         end
      end
      chk("t4_beats", 64'(b), 64'd8);
      @(negedge clk);
      axi_rvalid_i = 1'b0; axi_rlast_i = 1'b0; dma_data_ready_and_i = 2'b11;
      #1 chk("t4_idle", {axi_rready_o, dma_data_v_o}, 64'd0);
      chk("t4_err", {error_o, error_cache_id_o}, 64'd3);

      // Asynchronous reset during the fourth read beat.
      start_txn("t6", 2'b01, 1'b0, 28'h0000300, 0, 28'h0000300);
      for (int bb = 0; bb < 3; bb++) begin
         @(negedge clk);
         axi_arready_i = 1'b0; axi_rvalid_i = 1'b1; axi_rdata_i = rd_pat(30, bb);
         axi_rlast_i = 1'b0; dma_data_ready_and_i = 2'b01;
      end
      @(negedge clk);
      axi_rvalid_i = 1'b1; axi_rdata_i = rd_pat(30, 3); dma_data_ready_and_i = 2'b01;
      #1 chk("t6_pre", {axi_rready_o, dma_data_v_o}, {1'b1, 2'b01});
      reset_i = 1'b1;
      #1 chk("t6_rst", {axi_rready_o, dma_data_v_o, error_o, error_cache_id_o}, 64'd0);
      @(negedge clk);
      reset_i = 1'b0; axi_rvalid_i = 1'b0; dma_data_ready_and_i = 2'b00;
      start_txn("t6b", 2'b10, 1'b0, 28'h00005C0, 1, 28'h00005C0);
      rd_beats("t6b", 1, 21, 2'b00, 1'b0, 1'b0, 1'b0);

      run_vec(vecs[8], 8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
